pa_fdsu_seq_ctrl: RTL
=====================

Name: pa_fdsu_seq_ctrl

Overview:
Sequencer for the single-precision FDSU divide/sqrt datapath. It accepts one issued div/sqrt op and drives the prepare stage's find-first-one operand selection for denormal operands, including the two-pass case where both divide operands are denormal. It then runs the fixed-count SRT iteration loop, a round cycle and a write-back request/grant handshake, and supports flush from any state.

Parameters:
ITER_NUM, 13, SRT iteration cycles (radix-4, 26 quotient bits for single precision)
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > ITER_NUM

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset, synchronous, active-high
ex1_start_vld  in  1  issue valid; accepted only when ctrl_ready=1
ex1_div  in  1  op is divide
ex1_sqrt  in  1  op is sqrt
ex1_op0_id  in  1  operand 0 denormal
ex1_op1_id  in  1  operand 1 denormal
ex1_special_vld  in  1  special-case result (NaN/inf/zero); no iteration needed
rtu_flush  in  1  kill in-flight op
wb_grant  in  1  write-back port granted
ctrl_ready  out  1  idle, can accept
fdsu_busy  out  1  op in flight
ex1_stall  out  1  upstream must hold EX1 operands this cycle
ex1_op1_sel  out  1  find-first-one operates on operand 1
id_f_wen  out  1  latch operand-0 denormal exponent/fraction into the _f registers
srt_first  out  1  load remainder/divisor, start iteration
srt_iter_vld  out  1  SRT iteration active
srt_last  out  1  final iteration
rnd_vld  out  1  round cycle
wb_req  out  1  result ready for write-back
wb_special  out  1  write-back carries special result
iter_cnt  out  CNT_W  remaining iterations

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst is synchronous and active-high.
- Reset value: while cpurst=1 and on the cycle after, state=IDLE and iter_cnt=0. All outputs are 0 while cpurst=1; ctrl_ready=1 from the first cycle after reset deasserts.
- States: IDLE, IDPREP, ITER, RND, WB. Encodings are one-hot.
- Outputs are combinational from state and the current accept, except iter_cnt, which is registered.
- Accept condition: acc = IDLE & ex1_start_vld & (ex1_div ^ ex1_sqrt) & !rtu_flush. A func with both or neither of div/sqrt set is ignored. A start while not IDLE is ignored.
- IDLE on acc, by priority:
  - ex1_special_vld: go to WB with wb_special latched to 1.
  - div & op0_id & op1_id: assert id_f_wen=1 and ex1_op1_sel=0 this cycle; go to IDPREP.
  - otherwise: assert srt_first=1, with ex1_op1_sel = div & op1_id & !op0_id; load iter_cnt=ITER_NUM-1; go to ITER.
- IDPREP (exactly 1 cycle): assert ex1_op1_sel=1, srt_first=1, ex1_stall=1; load iter_cnt=ITER_NUM-1; go to ITER.
- ITER:
  - srt_iter_vld=1; iter_cnt decrements each cycle.
  - srt_last=1 when iter_cnt==0; the next state after that cycle is RND.
  - The counter never wraps; it holds 0 outside ITER.
- RND: rnd_vld=1 for 1 cycle; go to WB.
- WB: wb_req=1 until wb_grant. On grant go to IDLE, clearing wb_special.
- fdsu_busy = !IDLE. ctrl_ready = IDLE & !cpurst.
- Flush: rtu_flush has highest priority over grant and accept. In any state the next state is IDLE, iter_cnt=0 and wb_special=0. A flush on the accept cycle cancels the accept, and no srt_first/id_f_wen is issued. A flush on the same cycle as wb_grant leaves the result discarded.
- Latency (accept at cycle T, no flush):
  - Normal op: ITER at T+1..T+ITER_NUM, RND at T+ITER_NUM+1, wb_req from T+ITER_NUM+2.
  - Double-denormal divide: every timing after T shifts by +1.
  - Special: wb_req at T+1.
- Upstream contract: EX1 operands must be held stable on every cycle that ex1_stall=1.

Decomposition:
- Shared defines header pa_fdsu_define:
  - FDSU state one-hot encodings (IDLE, IDPREP, ITER, RND, WB)
  - FDSU_ITER_NUM_S = 13
  - FDSU_CNT_W = 5
- One sub-module is natural: pa_fdsu_iter_cnt, the loadable down-counter. It has load, dec and clr inputs and is_zero and cnt outputs.

Test Plan:
- Div, no denormals, start at T=10, grant at 27: srt_first@10; srt_iter_vld@11..23; srt_last@23; rnd_vld@24; wb_req@25..27; ctrl_ready=1@28.
- Div, op0_id=op1_id=1, start at T=10: id_f_wen=1 and ex1_op1_sel=0 @10; ex1_op1_sel=1, srt_first=1 and ex1_stall=1 @11; srt_last@24; wb_req@26.
- Sqrt with ex1_special_vld=1 at T=10: no srt_first/srt_iter_vld; wb_req=1 and wb_special=1 @11; grant@11 -> ctrl_ready=1 @12 and wb_special=0.
- Flush while iter_cnt=7 in ITER at T=15: @16 state IDLE, iter_cnt=0, ctrl_ready=1; no rnd_vld or wb_req follows. Flush on the accept cycle -> no srt_first.
- ex1_start_vld with div=sqrt=1, or with div=sqrt=0, in IDLE -> ignored, ctrl_ready stays 1. A valid start during ITER -> ignored, iter count unaffected.
- cpurst=1 while in WB with wb_req=1: outputs 0 while reset is held; the first cycle after deassert has ctrl_ready=1 and wb_req=0. Div-only op1_id=1 start -> ex1_op1_sel=1 on the accept cycle.

Source files
------------

// File: rtl/pa_fdsu_define.sv
// Shared definitions for the FDSU divide/sqrt sequencer: state encodings
// and the single-precision iteration constants.
package pa_fdsu_define;

   // Radix-4 SRT produces 2 quotient bits per cycle; 26 bits -> 13 cycles.
   localparam int FDSU_ITER_NUM_S = 13;
   localparam int FDSU_CNT_W      = 5;

   // One-hot sequencer states.
   typedef enum logic [4:0] {
      FDSU_IDLE   = 5'b00001,
      FDSU_IDPREP = 5'b00010,
      FDSU_ITER   = 5'b00100,
      FDSU_RND    = 5'b01000,
      FDSU_WB     = 5'b10000
   } fdsu_state_e;

endpackage

// File: rtl/pa_fdsu_iter_cnt.sv
// Loadable down-counter tracking the remaining SRT iterations.
// Priority: clr > load > dec. Decrement saturates at zero so the count
// never wraps.
module pa_fdsu_iter_cnt
   import pa_fdsu_define::*;
#(
   parameter int               CNT_W    = FDSU_CNT_W,
   parameter logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FDSU_ITER_NUM_S - 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             is_zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, reload or saturating decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/pa_fdsu_seq_ctrl.sv
// Sequencer for the single-precision FDSU divide/sqrt datapath.
// Walks one op through optional denormal prepare, the SRT loop, rounding
// and write-back.
//
// Handshakes:
//   issue  : an op is taken on a cycle where ctrl_ready=1, ex1_start_vld=1,
//            exactly one of ex1_div/ex1_sqrt is set and rtu_flush=0;
//            anything else on ex1_start_vld is dropped, never queued.
//   result : wb_req stays high from entry into WB until the cycle wb_grant
//            is seen; that cycle completes the op. rtu_flush on any cycle
//            (including a grant cycle) kills the op and returns to IDLE.
module pa_fdsu_seq_ctrl
   import pa_fdsu_define::*;
#(
   parameter int ITER_NUM = FDSU_ITER_NUM_S,
   // Must satisfy 2**CNT_W > ITER_NUM.
   parameter int CNT_W    = FDSU_CNT_W
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             ex1_start_vld,
   input  logic             ex1_div,
   input  logic             ex1_sqrt,
   input  logic             ex1_op0_id,
   input  logic             ex1_op1_id,
   input  logic             ex1_special_vld,
   input  logic             rtu_flush,
   input  logic             wb_grant,
   output logic             ctrl_ready,
   output logic             fdsu_busy,
   output logic             ex1_stall,
   output logic             ex1_op1_sel,
   output logic             id_f_wen,
   output logic             srt_first,
   output logic             srt_iter_vld,
   output logic             srt_last,
   output logic             rnd_vld,
   output logic             wb_req,
   output logic             wb_special,
   output logic [CNT_W-1:0] iter_cnt
);

   fdsu_state_e      state_q;
   fdsu_state_e      state_d;
   logic             wb_special_q;
   logic             wb_special_d;

   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   logic             acc;
   logic             dbl_den;

   logic             stall_raw;
   logic             op1_sel_raw;
   logic             id_f_wen_raw;
   logic             srt_first_raw;
   logic             iter_vld_raw;
   logic             last_raw;
   logic             rnd_raw;
   logic             wb_req_raw;

   // Issue is taken only in IDLE, for a well-formed func, and not while flushing.
   assign acc     = (state_q == FDSU_IDLE) & ex1_start_vld
                  & (ex1_div ^ ex1_sqrt) & ~rtu_flush;
   // Both divide operands denormal: normalise op0 first, then op1 next cycle.
   assign dbl_den = ex1_div & ex1_op0_id & ex1_op1_id;

   pa_fdsu_iter_cnt #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (CNT_W'(ITER_NUM - 1))
   ) u_iter_cnt (
      .clk     (forever_cpuclk),
      .rst     (cpurst),
      .load    (cnt_load),
      .dec     (cnt_dec),
      .clr     (cnt_clr),
      .cnt     (cnt_val),
      .is_zero (cnt_zero)
   );

   // Next-state and per-state strobes; flush overrides everything at the end.
   always_comb begin
      state_d       = state_q;
      wb_special_d  = wb_special_q;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      cnt_clr       = 1'b0;
      stall_raw     = 1'b0;
      op1_sel_raw   = 1'b0;
      id_f_wen_raw  = 1'b0;
      srt_first_raw = 1'b0;
      iter_vld_raw  = 1'b0;
      last_raw      = 1'b0;
      rnd_raw       = 1'b0;
      wb_req_raw    = 1'b0;

      case (state_q)
         FDSU_IDLE: begin
            if (acc) begin
               if (ex1_special_vld) begin
                  wb_special_d = 1'b1;
                  state_d      = FDSU_WB;
               end else if (dbl_den) begin
                  // Capture op0's normalised exponent/fraction this cycle.
                  id_f_wen_raw = 1'b1;
                  state_d      = FDSU_IDPREP;
               end else begin
                  srt_first_raw = 1'b1;
                  op1_sel_raw   = ex1_div & ex1_op1_id & ~ex1_op0_id;
                  cnt_load      = 1'b1;
                  state_d       = FDSU_ITER;
               end
            end
         end
         FDSU_IDPREP: begin
            // Second pass: find-first-one on op1 while EX1 operands are held.
            op1_sel_raw   = 1'b1;
            srt_first_raw = 1'b1;
            stall_raw     = 1'b1;
            cnt_load      = 1'b1;
            state_d       = FDSU_ITER;
         end
         FDSU_ITER: begin
            iter_vld_raw = 1'b1;
            if (cnt_zero) begin
               last_raw = 1'b1;
               state_d  = FDSU_RND;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         FDSU_RND: begin
            rnd_raw = 1'b1;
            state_d = FDSU_WB;
         end
         FDSU_WB: begin
            wb_req_raw = 1'b1;
            if (wb_grant) begin
               wb_special_d = 1'b0;
               state_d      = FDSU_IDLE;
            end
         end
         default: begin
            state_d = FDSU_IDLE;
         end
      endcase

      if (rtu_flush) begin
         state_d      = FDSU_IDLE;
         wb_special_d = 1'b0;
         cnt_clr      = 1'b1;
      end
   end

   // State and special-result flag registers.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q      <= FDSU_IDLE;
         wb_special_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wb_special_q <= wb_special_d;
      end
   end

   // Every output is forced low while reset is held, even before the state
   // register has been cleared by the first reset edge.
   assign ctrl_ready   = (state_q == FDSU_IDLE) & ~cpurst;
   assign fdsu_busy    = (state_q != FDSU_IDLE) & ~cpurst;
   assign ex1_stall    = stall_raw     & ~cpurst;
   assign ex1_op1_sel  = op1_sel_raw   & ~cpurst;
   assign id_f_wen     = id_f_wen_raw  & ~cpurst;
   assign srt_first    = srt_first_raw & ~cpurst;
   assign srt_iter_vld = iter_vld_raw  & ~cpurst;
   assign srt_last     = last_raw      & ~cpurst;
   assign rnd_vld      = rnd_raw       & ~cpurst;
   assign wb_req       = wb_req_raw    & ~cpurst;
   assign wb_special   = wb_special_q  & ~cpurst;
   assign iter_cnt     = cpurst ? '0 : cnt_val;

endmodule
